// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter: counting controls driven by the
// master side, registered count and terminal-count pulse returned by the
// counter (slave side). clk and reset stay as plain scalar ports.
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;

  modport master (
    output en, up, mode, load, load_val,
    input  out, tc
  );

  modport slave (
    input  en, up, mode, load, load_val,
    output out, tc
  );
endinterface

// File: rtl/mod_counter.sv
// mod_counter: modulo-N up/down counter with four run-time moduli, load
// (clamped to the active limit) and a registered one-cycle terminal-count
// pulse. Optional prescaler enabled by defining MOD_COUNTER_PRESCALE_EN:
// with it, only every PRESCALE-th enabled cycle is a counter step.
module mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MOD0     = 10,
  parameter int MOD1     = 12,
  parameter int MOD2     = 14,
  parameter int MOD3     = 16,
  parameter int PRESCALE = 4
) (
  input  logic          clk,
  input  logic          reset,
  mod_counter_if.slave  bus
);

  // Limits carry one extra bit so MODn = 2**WIDTH compares cleanly.
  localparam logic [WIDTH:0]   LIM0 = (WIDTH+1)'(MOD0 - 1);
  localparam logic [WIDTH:0]   LIM1 = (WIDTH+1)'(MOD1 - 1);
  localparam logic [WIDTH:0]   LIM2 = (WIDTH+1)'(MOD2 - 1);
  localparam logic [WIDTH:0]   LIM3 = (WIDTH+1)'(MOD3 - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // Elaboration-time sanity checks on the configuration.
  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("mod_counter: WIDTH must be 2..16");
  end
  if (MOD0 < 2 || MOD0 > (1 << WIDTH) || MOD1 < 2 || MOD1 > (1 << WIDTH) ||
      MOD2 < 2 || MOD2 > (1 << WIDTH) || MOD3 < 2 || MOD3 > (1 << WIDTH)) begin : g_bad_mod
    $error("mod_counter: each MODn must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_counter: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic [WIDTH:0]   lim;
  logic [WIDTH:0]   out_ext;
  logic [WIDTH:0]   ld_ext;
  logic             step;

`ifdef MOD_COUNTER_PRESCALE_EN
  // A 1-bit counter is kept for PRESCALE = 1; it then never leaves 0.
  localparam int             PCW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_TOP = PCW'(PRESCALE - 1);
  localparam logic [PCW-1:0] PC_ONE = PCW'(1);

  logic [PCW-1:0] pc_q, pc_d;

  // Prescale counter: advances on enabled cycles, clears on load or on the
  // cycle that produces a counter step.
  always_comb begin
    pc_d = pc_q;
    step = 1'b0;
    if (bus.load) begin
      pc_d = '0;
    end else if (bus.en) begin
      if (pc_q == PC_TOP) begin
        pc_d = '0;
        step = 1'b1;
      end else begin
        pc_d = pc_q + PC_ONE;
      end
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end
`else
  // Without the prescaler every enabled cycle is a step.
  always_comb begin
    step = bus.en;
  end
`endif

  // Active limit follows mode combinationally so a mode change applies on
  // the very next edge without restarting the count.
  always_comb begin
    unique case (bus.mode)
      2'b00:   lim = LIM0;
      2'b01:   lim = LIM1;
      2'b10:   lim = LIM2;
      default: lim = LIM3;
    endcase
  end

  // Next count and terminal-count: load beats enable; tc only pulses on a wrap.
  always_comb begin
    out_ext = {1'b0, out_q};
    ld_ext  = {1'b0, bus.load_val};
    out_d   = out_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      out_d = (ld_ext <= lim) ? bus.load_val : lim[WIDTH-1:0];
    end else if (step) begin
      if (bus.up) begin
        if (out_ext >= lim) begin
          out_d = '0;
          tc_d  = 1'b1;
        end else begin
          out_d = out_q + ONE;
        end
      end else begin
        if (out_q == '0) begin
          out_d = lim[WIDTH-1:0];
          tc_d  = 1'b1;
        end else if (out_ext > lim) begin
          // Left above range by a mode shrink: settle on the new limit.
          out_d = lim[WIDTH-1:0];
        end else begin
          out_d = out_q - ONE;
        end
      end
    end
  end

  // Count and tc registers; reset clears both without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.out = out_q;
  assign bus.tc  = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed scenarios plus random
// stimulus, all compared against a behavioural model of the counting rules.
module tb_mod_counter;
  localparam int W = 4;
  localparam int MODS [4] = '{10, 12, 14, 16};
`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic clk;
  logic reset;

  mod_counter_if #(.WIDTH(W)) bus ();

  mod_counter #(
    .WIDTH(W), .MOD0(10), .MOD1(12), .MOD2(14), .MOD3(16), .PRESCALE(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  int m_out = 0;
  int m_tc  = 0;
  int m_pc  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge worth of behaviour, from the rules in plain integers.
  task automatic model_edge();
    int lim;
    bit stepping;
    lim = MODS[bus.mode] - 1;
    if (bus.load) begin
      m_out = (int'(bus.load_val) > lim) ? lim : int'(bus.load_val);
      m_tc  = 0;
      m_pc  = 0;
    end else if (bus.en) begin
      stepping = (m_pc == PS - 1);
      m_pc     = stepping ? 0 : m_pc + 1;
      m_tc     = 0;
      if (stepping) begin
        if (bus.up) begin
          if (m_out >= lim) begin m_out = 0; m_tc = 1; end
          else m_out = m_out + 1;
        end else begin
          if (m_out == 0) begin m_out = lim; m_tc = 1; end
          else if (m_out > lim) m_out = lim;
          else m_out = m_out - 1;
        end
      end
    end else begin
      m_tc = 0;
    end
  endtask

  // Called 1 time unit after an edge; advances one clock and compares.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".out"}, int'(bus.out), m_out);
    check({tag, ".tc"}, int'(bus.tc), m_tc);
  endtask

  // Asynchronous reset pulse placed between edges; checked before any edge.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, ".rst_out"}, int'(bus.out), 0);
    check({tag, ".rst_tc"}, int'(bus.tc), 0);
    m_out = 0; m_tc = 0; m_pc = 0;
    #2;
    reset = 1'b0;
  endtask

  task automatic set_in(input bit en, input bit up, input int mode,
                        input bit load, input int lv);
    bus.en       = en;
    bus.up       = up;
    bus.mode     = 2'(mode);
    bus.load     = load;
    bus.load_val = W'(lv);
  endtask

  initial begin
    int tcs;
    int guard;
    reset = 1'b1;
    set_in(0, 1, 0, 0, 0);
    #12;
    check("reset.out", int'(bus.out), 0);
    check("reset.tc", int'(bus.tc), 0);
    #1 reset = 1'b0;
    tick("idle");

    // Count to 7, then reset asynchronously mid-count.
    set_in(1, 1, 0, 0, 0);
    guard = 0;
    while (m_out != 7 && guard < 100) begin
      tick("to7");
      guard++;
    end
    check("reach7", int'(bus.out), 7);
    #2;
    pulse_reset("midcount");
    for (int i = 0; i < 3 * PS; i++) tick("restart");

    // Up wrap in mode 00 over 12 steps.
    pulse_reset("upwrap");
    set_in(1, 1, 0, 0, 0);
    for (int i = 0; i < 12 * PS; i++) tick("upwrap");

    // Down wrap in mode 01 from 0.
    set_in(0, 0, 1, 1, 0);
    tick("dnload");
    set_in(1, 0, 1, 0, 0);
    for (int i = 0; i < 3 * PS; i++) tick("dnwrap");

    // Mode shrink 11 -> 00 at out = 13, counting up then down.
    set_in(0, 1, 3, 1, 13);
    tick("shr_ld");
    set_in(1, 1, 0, 0, 0);
    for (int i = 0; i < PS; i++) tick("shr_up");
    check("shr_up_val", int'(bus.out), 0);
    set_in(0, 0, 3, 1, 13);
    tick("shr_ld2");
    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < PS; i++) tick("shr_dn");
    check("shr_dn_val", int'(bus.out), 9);

    // Load clamps and outranks enable; plain load with en low.
    set_in(1, 1, 2, 1, 15);
    tick("ld_clamp");
    check("ld_clamp_val", int'(bus.out), 13);
    set_in(0, 1, 2, 1, 5);
    tick("ld_plain");
    check("ld_plain_val", int'(bus.out), 5);

    // 40 enabled edges from a clean start: count tc pulses.
    set_in(0, 1, 0, 0, 0);
    tick("pre40");
    pulse_reset("cnt40");
    set_in(1, 1, 0, 0, 0);
    tcs = 0;
    for (int i = 0; i < 40; i++) begin
      tick("cnt40");
      if (bus.tc) tcs++;
    end
    check("tc_count40", tcs, (PS == 4) ? 1 : 4);

    // Load mid-interval restarts the prescale interval.
    pulse_reset("pcload");
    set_in(1, 1, 0, 0, 0);
    tick("pc_a");
    tick("pc_b");
    set_in(1, 1, 0, 1, 3);
    tick("pc_ld");
    set_in(1, 1, 0, 0, 0);
    for (int i = 0; i < 2 * PS + 1; i++) tick("pc_run");

    // Random stimulus with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 15) == 0,
             $urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) pulse_reset("rnd");
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised modulo-N counter with four run-time-selectable moduli. It supports up/down direction, count enable, synchronous load and a registered terminal-count pulse. It is the general-purpose replacement for the fixed 4-bit mode counter, for use in timers, digit scanners and cascaded BCD-style chains (tc of one stage drives en of the next).

Parameters:
WIDTH, 4, counter width in bits; 2..16
MOD0, 10, modulus for mode 2'b00; count range 0..MOD0-1
MOD1, 12, modulus for mode 2'b01
MOD2, 14, modulus for mode 2'b10
MOD3, 16, modulus for mode 2'b11; each MODn must satisfy 2 <= MODn <= 2**WIDTH
PRESCALE, 4, divide ratio for the optional prescaler; >= 1; ignored unless the macro is defined

Ports:
clk  input  1  clock; all state updates on the rising edge only
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; one step per enabled cycle
up  input  1  direction: 1 = increment, 0 = decrement
mode  input  2  modulus select (MOD0..MOD3); sampled every cycle, no register
load  input  1  synchronous load strobe
load_val  input  WIDTH  load value
out  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered); high for one cycle after a wrap

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high.
- Reset: out = 0 and tc = 0 immediately, with no dependence on clk. On deassertion, counting resumes at the first following rising edge. Reset has highest priority.
- Mod select: M = MODn selected by the current mode; lim = M-1. All compares use WIDTH+1 bits so M = 2**WIDTH needs no overflow handling.
- Priority each rising edge: reset > load > en > hold.
- load = 1:
  - out <= load_val if load_val <= lim; otherwise out <= lim (clamped).
  - tc <= 0. This applies regardless of en and up.
- en = 1, up = 1:
  - if out >= lim: out <= 0, tc <= 1.
  - else: out <= out+1, tc <= 0.
- en = 1, up = 0:
  - if out == 0: out <= lim, tc <= 1.
  - if out > lim (possible after a mode change): out <= lim, tc <= 0.
  - else: out <= out-1, tc <= 0.
- en = 0, no load: out holds; tc <= 0, so tc is never held longer than one cycle.
- Latency: one step of out per enabled edge. tc is high in the same cycle out shows the wrapped value.
- Mode change mid-count:
  - Takes effect on the next edge, with no restart.
  - Counting up from out >= new lim wraps to 0 with tc = 1 (rule above).
- Direction change mid-count: takes effect on the next edge, from the current value.
- Cascading: the downstream stage's en is driven by tc, so it steps one cycle after the upstream wrap. This fixed skew is accepted.

Optional Feature:
MOD_COUNTER_PRESCALE_EN
- Defined:
  - Adds a ceil(log2(PRESCALE))-bit prescale counter pc, reset to 0.
  - pc advances on each en = 1 cycle. A counter step (and any tc) happens only on the enabled cycle where pc == PRESCALE-1; pc then returns to 0.
  - load and reset clear pc to 0. en = 0 holds pc.
  - PRESCALE = 1 is equivalent to the macro being undefined.
- Undefined: no prescaler logic; every en = 1 cycle is a counter step. The PRESCALE parameter is unused.

Test Plan:
1. Reset mid-count: reset asserted between edges at out = 7 -> out = 0 and tc = 0 immediately (before the next edge); counting restarts from 0 after release.
2. Up wrap: mode = 00, up = 1, en = 1 for 12 cycles from 0 -> out 1..9, 0, 1, 2; tc = 1 only in the cycle out becomes 0.
3. Down wrap: mode = 01, up = 0, start out = 0 -> out = 11 with tc = 1, then 10, 9.
4. Mode shrink: mode = 11, count up to 13, switch to mode = 00:
   - with up = 1, next edge -> out = 0, tc = 1;
   - alternatively with up = 0, next edge -> out = 9, tc = 0.
5. Load and priority:
   - mode = 10, load = 1, load_val = 15, en = 1 -> out = 13 (clamped), tc = 0;
   - load_val = 5 with en = 0 -> out = 5.
6. Prescaler (macro defined, PRESCALE = 4): mode = 00, en = 1 held -> out increments every 4th edge; 40 enabled edges give exactly one tc.
   - A load at pc = 2 restarts the 4-cycle interval.
   - Macro undefined: same stimulus gives 4 tc pulses.
